// File: rtl/hilo_divu_ctrl_pkg.sv
// Shared definitions for the HI/LO divide sequencer: funct codes common with
// the EX result select and ALU control, and the sequencer FSM state encoding.
package hilo_divu_ctrl_pkg;

    localparam int unsigned FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] DIVU = 6'b011011;
    localparam logic [FUNCT_W-1:0] MFHI = 6'b010000;
    localparam logic [FUNCT_W-1:0] MFLO = 6'b010010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for every funct that depends on (or produces) HI/LO.
    function automatic logic is_hilo_op(input logic [FUNCT_W-1:0] funct);
        return (funct == DIVU) || (funct == MFHI) || (funct == MFLO);
    endfunction

endpackage

// File: rtl/divu_step.sv
// One iteration of restoring shift-subtract unsigned division.
// Ports:
//   r_i  partial remainder (WIDTH+1 bits)   q_i  quotient/dividend shift register
//   d_i  divisor                            r_o/q_o  values after this iteration
module divu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted_c;
    logic [WIDTH:0] trial_c;

    // The remainder stays below the divisor, so its top bit is always zero.
    logic unused_r_msb;
    assign unused_r_msb = r_i[WIDTH];

    assign shifted_c = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
    assign trial_c   = shifted_c - {1'b0, d_i};

    // Keep the subtraction only when it did not borrow.
    always_comb begin
        r_o = shifted_c;
        q_o = {q_i[WIDTH-2:0], 1'b0};
        if (!trial_c[WIDTH]) begin
            r_o = trial_c;
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/hilo_divu_ctrl.sv
// EX-stage unsigned divide sequencer and HI/LO register owner.
// A DIVU accepted from IDLE or DONE runs WIDTH shift-subtract iterations, one
// per cycle; the last iteration writes LO (quotient) and HI (remainder).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   issue, Signal     EX instruction valid and its funct field
//   dataA, dataB      dividend / divisor, sampled only on the accept edge
//   stall             combinational hold of IF/ID/EX while a HI/LO op waits
//   busy, done        RUN indicator, one-cycle fresh-result pulse
//   hi_out, lo_out    HI (remainder) and LO (quotient) registers
module hilo_divu_ctrl
    import hilo_divu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   r_step_c;
    logic [WIDTH-1:0] q_step_c;
    logic             accept_c;

    divu_step #(
        .WIDTH (WIDTH)
    ) u_divu_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (r_step_c),
        .q_o (q_step_c)
    );

    // A new divide may start whenever no divide is in flight.
    assign accept_c = issue && (Signal == DIVU) && (state_q != ST_RUN);

    // Next-state, datapath and HI/LO update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    q_d     = dataA;
                    r_d     = '0;
                    d_d     = dataB;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                q_d   = q_step_c;
                r_d   = r_step_c;
                cnt_d = CNT_W'(cnt_q + 1'b1);
                // Result commits on the same edge as the final iteration.
                if (cnt_q == CNT_LAST) begin
                    lo_d    = q_step_c;
                    hi_d    = r_step_c[WIDTH-1:0];
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Only HI/LO consumers and a second DIVU must wait for the running divide.
    assign stall  = issue && (state_q == ST_RUN) && is_hilo_op(Signal);
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_divu_ctrl.sv
// Directed bench for hilo_divu_ctrl: a table of divides checked for latency and
// result, plus hand-written interlock, back-to-back and mid-divide reset cases.
module tb_hilo_divu_ctrl;
    import hilo_divu_ctrl_pkg::*;

    localparam int unsigned W = 32;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SRL = 6'b000010;

    logic         clk = 1'b0;
    logic         reset;
    logic         issue;
    logic [5:0]   Signal;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] quo;
        logic [W-1:0] rem;
    } vec_t;

    vec_t vecs[10];

    hilo_divu_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .issue  (issue),
        .Signal (Signal),
        .dataA  (dataA),
        .dataB  (dataB),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next cycle; inputs are driven 2 time units after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Accept a DIVU in cycle 0 (caller is at the start of a cycle, FSM not in RUN),
    // check busy/done/HI/LO through cycle 34. pq/pr are the HI/LO values in place
    // before this divide; they must not move until the final edge.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic [W-1:0] pq, input logic [W-1:0] pr);
        issue  = 1'b1;
        Signal = DIVU;
        dataA  = a;
        dataB  = b;
        #1;
        chk_bit("accept_no_stall", stall, 1'b0);
        next_cycle();
        issue = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            dataA = $urandom;
            dataB = $urandom;
            #1;
            chk_bit("run_busy", busy, 1'b1);
            chk_bit("run_done", done, 1'b0);
            if (c == 1 || c == 32) begin
                chk("run_lo_hold", lo_out, pq);
                chk("run_hi_hold", hi_out, pr);
            end
            next_cycle();
        end
        #1;
        chk_bit("c33_done", done, 1'b1);
        chk_bit("c33_busy", busy, 1'b0);
        chk("c33_lo", lo_out, eq);
        chk("c33_hi", hi_out, er);
        next_cycle();
        #1;
        chk_bit("c34_done", done, 1'b0);
        chk_bit("c34_busy", busy, 1'b0);
        chk("c34_lo", lo_out, eq);
    endtask

    initial begin
        logic [W-1:0] prev_q;
        logic [W-1:0] prev_r;

        vecs[0] = '{a: 32'd100,        b: 32'd7,          quo: 32'd14,       rem: 32'd2};
        vecs[1] = '{a: 32'd5,          b: 32'd0,          quo: 32'hFFFFFFFF, rem: 32'd5};
        vecs[2] = '{a: 32'hFFFFFFFF,   b: 32'd1,          quo: 32'hFFFFFFFF, rem: 32'd0};
        vecs[3] = '{a: 32'd3,          b: 32'h80000000,   quo: 32'd0,        rem: 32'd3};
        vecs[4] = '{a: 32'd9,          b: 32'd2,          quo: 32'd4,        rem: 32'd1};
        vecs[5] = '{a: 32'd0,          b: 32'd5,          quo: 32'd0,        rem: 32'd0};
        vecs[6] = '{a: 32'd7,          b: 32'd7,          quo: 32'd1,        rem: 32'd0};
        vecs[7] = '{a: 32'd6,          b: 32'd7,          quo: 32'd0,        rem: 32'd6};
        vecs[8] = '{a: 32'hDEADBEEF,   b: 32'd16,         quo: 32'h0DEADBEE, rem: 32'hF};
        vecs[9] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   quo: 32'd1,        rem: 32'd0};

        reset  = 1'b1;
        issue  = 1'b0;
        Signal = 6'd0;
        dataA  = '0;
        dataB  = '0;
        next_cycle();
        next_cycle();
        #1;
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_stall", stall, 1'b0);
        chk("rst_hi", hi_out, '0);
        chk("rst_lo", lo_out, '0);
        reset = 1'b0;

        // issue=0 with a DIVU funct must not start anything.
        Signal = DIVU;
        dataA  = 32'd100;
        dataB  = 32'd7;
        next_cycle();
        #1;
        chk_bit("noissue_busy", busy, 1'b0);
        chk_bit("noissue_stall", stall, 1'b0);

        // Table of divides.
        prev_q = '0;
        prev_r = '0;
        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].quo, vecs[i].rem, prev_q, prev_r);
            prev_q = vecs[i].quo;
            prev_r = vecs[i].rem;
            next_cycle();
        end

        // MFHI interlock, with unrelated functs and MFLO mixed in during RUN.
        issue  = 1'b1;
        Signal = DIVU;
        dataA  = 32'd100;
        dataB  = 32'd7;
        next_cycle();
        for (int c = 1; c <= 32; c++) begin
            case (c)
                5:       Signal = F_ADD;
                6:       Signal = F_SRL;
                20:      Signal = MFLO;
                default: Signal = MFHI;
            endcase
            #1;
            if (c == 5 || c == 6) chk_bit("nonhilo_no_stall", stall, 1'b0);
            else                  chk_bit("hilo_stall", stall, 1'b1);
            if (c == 32) chk("mfhi_old_hi", hi_out, prev_r);
            next_cycle();
        end
        Signal = MFHI;
        #1;
        chk_bit("mfhi_release", stall, 1'b0);
        chk("mfhi_new_hi", hi_out, 32'd2);
        chk_bit("mfhi_done", done, 1'b1);
        issue = 1'b0;
        next_cycle();
        next_cycle();

        // Back-to-back DIVU: second one held until the DONE cycle.
        issue  = 1'b1;
        Signal = DIVU;
        dataA  = 32'd100;
        dataB  = 32'd7;
        next_cycle();
        dataA = 32'd9;
        dataB = 32'd2;
        for (int c = 1; c <= 32; c++) begin
            #1;
            chk_bit("b2b_stall", stall, 1'b1);
            next_cycle();
        end
        #1;
        chk_bit("b2b_release", stall, 1'b0);
        chk_bit("b2b_done1", done, 1'b1);
        chk("b2b_lo1", lo_out, 32'd14);
        chk("b2b_hi1", hi_out, 32'd2);
        next_cycle();
        issue = 1'b0;
        dataA = 32'hFFFFFFFF;
        dataB = 32'd3;
        for (int c = 34; c <= 65; c++) begin
            #1;
            chk_bit("b2b_busy2", busy, 1'b1);
            next_cycle();
        end
        #1;
        chk_bit("b2b_done2", done, 1'b1);
        chk("b2b_lo2", lo_out, 32'd4);
        chk("b2b_hi2", hi_out, 32'd1);
        next_cycle();
        next_cycle();

        // Reset in cycle 10 of a 100/7 divide.
        issue  = 1'b1;
        Signal = DIVU;
        dataA  = 32'd100;
        dataB  = 32'd7;
        next_cycle();
        issue = 1'b0;
        for (int c = 1; c <= 9; c++) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset  = 1'b0;
        issue  = 1'b1;
        Signal = MFHI;
        #1;
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_done", done, 1'b0);
        chk_bit("midrst_stall", stall, 1'b0);
        chk("midrst_hi", hi_out, '0);
        chk("midrst_lo", lo_out, '0);
        issue = 1'b0;
        for (int c = 12; c <= 40; c++) begin
            next_cycle();
            #1;
            chk_bit("midrst_no_done", done, 1'b0);
        end
        next_cycle();
        run_div(32'd100, 32'd7, 32'd14, 32'd2, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_divu_ctrl.md
# hilo_divu_ctrl

Multi-cycle sequencer for the unsigned divide unit and owner of the HI/LO register pair in the EX stage. It accepts a DIVU from the EX stage and runs a 32-iteration restoring shift-subtract division, one iteration per cycle. It writes the quotient and remainder into LO and HI, and raises a pipeline stall when an MFHI, MFLO or second DIVU arrives before the result exists. `hi_out` and `lo_out` feed the HiOut/LoOut inputs of the EX result select.

## Interface
Parameters:
- `WIDTH`, 32, operand, HI and LO width. Iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  synchronous, active-high. Sampled only at the rising edge of `clk`.
- `issue`  in  1  an EX-stage instruction is valid this cycle.
- `Signal`  in  6  funct field of the EX-stage instruction.
- `dataA`  in  WIDTH  dividend (rs).
- `dataB`  in  WIDTH  divisor (rt).
- `stall`  out  1  combinational; hold IF/ID/EX this cycle.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; HI/LO hold a fresh result.
- `hi_out`  out  WIDTH  HI register (remainder).
- `lo_out`  out  WIDTH  LO register (quotient).

## Operation
- Funct codes:
  - DIVU = 6'b011011
  - MFHI = 6'b010000
  - MFLO = 6'b010010
  - All other codes are ignored; they never stall and never start a divide.
- Internal state:
  - FSM: IDLE, RUN, DONE.
  - 5-bit iteration counter `cnt`.
  - Quotient/dividend shift register `q`, WIDTH bits.
  - Partial remainder `r`, WIDTH+1 bits.
  - Latched divisor `d`, WIDTH bits.
- Accept condition: `issue && Signal==DIVU` while in IDLE or DONE.
  - Load `q<=dataA`, `r<=0`, `d<=dataB`, `cnt<=0`.
  - Next state is RUN. This DIVU does not stall.
- One iteration per RUN cycle:
  - `t = {r[WIDTH-1:0], q[WIDTH-1]} - {1'b0, d}`.
  - If `t` is non-negative (bit WIDTH clear): `r<=t`, `q<={q[WIDTH-2:0],1}`.
  - Otherwise: `r<={r[WIDTH-1:0], q[WIDTH-1]}`, `q<={q[WIDTH-2:0],0}`.
  - `cnt<=cnt+1`.
- Last iteration (`cnt==WIDTH-1`):
  - The same edge writes `lo<=` the final quotient and `hi<=` the final remainder's low WIDTH bits.
  - Next state is DONE.
- DONE lasts exactly one cycle:
  - `done=1`.
  - Goes to IDLE, or to RUN if a DIVU is accepted that cycle.
- Divide by zero needs no special casing. The algorithm yields LO = all ones and HI = dividend, and that is the required result.
- Stall rule: `stall = issue && (state==RUN) && Signal ∈ {DIVU, MFHI, MFLO}`. It is never asserted in IDLE or DONE.
- HI/LO change only on the final-iteration edge or on reset. An aborted divide never writes them.

## Timing
- Reset values, applied at the first rising edge with `reset=1`:
  - State IDLE, `cnt=0`.
  - `hi_out=0`, `lo_out=0`.
  - `busy=0`, `done=0`, `stall=0`.
  - `q`, `r`, `d` cleared.
- Reset has priority over every other event, including mid-RUN. The divide is abandoned and HI/LO read 0.
- Latency, with the DIVU accepted in cycle 0:
  - Cycles 1..32 are RUN, with `busy=1`.
  - New `hi_out`/`lo_out` are visible in cycle 33.
  - `done=1` in cycle 33.
  - Back in IDLE in cycle 34.
- Stalled MFHI/MFLO: an MFHI/MFLO held by `stall` is released in cycle 33 and reads the new value in that same cycle.
- Stalled second DIVU: it is held through cycle 32 and accepted in cycle 33 from DONE. No idle bubble is inserted.
- `issue=0` never stalls and never starts a divide.
- `dataA`/`dataB` are sampled only on the accept edge. Changes during RUN are ignored.

## Structure
- Shared package contents:
  - The funct constants DIVU, MFHI, MFLO, kept common with the EX result select and the ALU control.
  - The FSM state enum.
- One sub-module: `divu_step`, purely combinational. It takes `r`, `q`, `d` and returns the next `r` and `q` for a single iteration.
- The controller holds the FSM, the counter, the operand registers and the HI/LO registers.

## Test plan
- Basic divide: DIVU with dataA=100, dataB=7 in cycle 0.
  - Cycle 33: `lo_out=14`, `hi_out=2`, `done=1`.
  - `busy=1` in cycles 1..32 only.
- Divide by zero: DIVU with dataA=5, dataB=0.
  - `lo_out=32'hFFFFFFFF`, `hi_out=5`.
  - No other behaviour differs from a normal divide.
- Full-range operands: DIVU with dataA=32'hFFFFFFFF, dataB=1 gives `lo_out=32'hFFFFFFFF`, `hi_out=0`.
  - Then DIVU with dataA=3, dataB=32'h80000000 gives `lo_out=0`, `hi_out=3`.
- MFHI interlock: DIVU with 100/7 in cycle 0, then MFHI issued from cycle 1.
  - `stall=1` in cycles 1..32, `stall=0` in cycle 33.
  - `hi_out=2` in cycle 33.
  - Non-HI/LO functs issued during RUN (ADD, SRL) never stall.
- Back-to-back DIVU: DIVU 100/7 in cycle 0, then DIVU 9/2 held from cycle 1.
  - Stalled through cycle 32, accepted in cycle 33.
  - Cycle 66: `lo_out=4`, `hi_out=1`.
- Reset mid-operation: assert `reset` in cycle 10 of a 100/7 divide.
  - Next cycle: IDLE, `hi_out=0`, `lo_out=0`, `busy=0`, no `done` pulse.
  - A following DIVU 100/7 completes normally 33 cycles after acceptance.
